ram_arbiter: RTL and testbench

//  Shares the single external SRAM between the RISC5 CPU and the video refresh reader.

---
 rtl/ram_arbiter_pkg.sv | 22 ++
 rtl/ram_arbiter_grant.sv | 64 ++++++
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the SRAM arbiter:
//   - FSM state encoding (IDLE, CPU_ACC, VID_ACC)
//   - be_decode(): SRAM byte-enable pattern for a CPU access
package ram_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CPU_ACC = 2'd1;
  localparam logic [1:0] VID_ACC = 2'd2;

  // Byte stores enable the single lane selected by the low address bits;
  // every read and every word store uses all four lanes.
  function automatic logic [3:0] be_decode(input logic [1:0] adr,
                                           input logic       ben,
                                           input logic       wr);
    logic [3:0] be;
    if (wr && ben) be = 4'b0001 << adr;
    else           be = 4'hF;
    return be;
  endfunction

endpackage

// File: rtl/ram_arbiter_grant.sv
// ram_arbiter_grant
//   Winner selection for the SRAM arbiter plus the fairness state.
//   Default build: video wins while it has fewer than MAX_VID_RUN consecutive
//   grants; a CPU grant clears the run counter.
//   RAM_ARBITER_RR_EN defined: a last-winner bit alternates grants when both
//   request (reset value = CPU, so video wins the first contention).
// Ports
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   arb_i      arbitration cycle (arbiter is in IDLE); fairness state updates
//   vid_req_i  video request
//   vid_win_o  1 = video granted this arbitration, 0 = CPU granted
module ram_arbiter_grant
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_VID_RUN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_i,
  input  logic vid_req_i,
  output logic vid_win_o
);

`ifdef RAM_ARBITER_RR_EN

  logic last_vid_q, last_vid_d;

  assign vid_win_o = vid_req_i && !last_vid_q;

  always_comb begin
    last_vid_d = last_vid_q;
    if (arb_i) last_vid_d = vid_win_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_vid_q <= 1'b0;
    else       last_vid_q <= last_vid_d;
  end

`else

  localparam logic [3:0] RUN_MAX = 4'(MAX_VID_RUN);

  logic [3:0] vrun_q, vrun_d;

  assign vid_win_o = vid_req_i && (vrun_q < RUN_MAX);

  always_comb begin
    vrun_d = vrun_q;
    if (arb_i) begin
      if (vid_win_o) vrun_d = (vrun_q == RUN_MAX) ? vrun_q : vrun_q + 4'd1;
      else           vrun_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vrun_q <= '0;
    else       vrun_q <= vrun_d;
  end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single external SRAM between the RISC5 CPU and the video
//   refresh reader. Generates the CPU memwait stall, muxes address, data and
//   byte lanes, and inserts WAIT_STATES extra cycles per SRAM access.
//   Optional build macro: RAM_ARBITER_RR_EN (strict round-robin arbitration).
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_adr/wr/ben/wdata      CPU request (CPU requests every cycle)
//   cpu_rdata, cpu_wait       read data and memwait stall to the CPU
//   vid_req/vid_adr           video word read request (held until vid_ack)
//   vid_ack, vid_rdata        video completion pulse and read data
//   mem_adr/ce/we/be/wdata    SRAM pins out
//   mem_rdata                 SRAM read data in
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MAX_VID_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              cpu_wr,
  input  logic              cpu_ben,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_wait,
  input  logic              vid_req,
  input  logic [ADDR_W-3:0] vid_adr,
  output logic              vid_ack,
  output logic [31:0]       vid_rdata,
  output logic [ADDR_W-3:0] mem_adr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic       WS_ZERO   = (WAIT_STATES == 0);
  localparam logic [2:0] WCNT_INIT = WS_ZERO ? 3'd0 : 3'(WAIT_STATES - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-3:0] adr_q, adr_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic arb;
  logic vid_win;
  logic done;
  logic is_vid;

  // IDLE is always an arbitration cycle: the CPU requests every cycle.
  assign arb = (state_q == IDLE);

  ram_arbiter_grant #(
    .MAX_VID_RUN (MAX_VID_RUN)
  ) u_grant (
    .clk_i     (clk),
    .rst_i     (rst),
    .arb_i     (arb),
    .vid_req_i (vid_req),
    .vid_win_o (vid_win)
  );

  // Access lines: driven straight from the winner in the arbitration cycle,
  // then replayed from the captured copy so they stay constant for the whole
  // access even if the video requester drops its request.
  always_comb begin
    adr_d   = adr_q;
    be_d    = be_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (arb) begin
      if (vid_win) begin
        adr_d = vid_adr;
        be_d  = 4'hF;
        we_d  = 1'b0;
      end else begin
        adr_d = cpu_adr[ADDR_W-1:2];
        be_d  = be_decode(cpu_adr[1:0], cpu_ben, cpu_wr);
        we_d  = cpu_wr;
      end
      wdata_d = cpu_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (!WS_ZERO) begin
          state_d = vid_win ? VID_ACC : CPU_ACC;
          wcnt_d  = WCNT_INIT;
        end
      end
      CPU_ACC, VID_ACC: begin
        if (wcnt_q == 3'd0) state_d = IDLE;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      adr_q   <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // With zero wait states the arbitration cycle is also the completion cycle.
  assign done   = arb ? WS_ZERO : (wcnt_q == 3'd0);
  assign is_vid = arb ? vid_win : (state_q == VID_ACC);

  // Strobes are gated by rst so they drop the moment reset is asserted,
  // including in the middle of an access.
  assign cpu_wait  = rst | ~(done & ~is_vid);
  assign vid_ack   = ~rst & done & is_vid;
  assign mem_ce    = ~rst;
  assign mem_we    = ~rst & we_d;
  assign mem_adr   = adr_d;
  assign mem_be    = be_d;
  assign mem_wdata = wdata_d;
  assign cpu_rdata = mem_rdata;
  assign vid_rdata = mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Two arbiter instances (WAIT_STATES=0 and WAIT_STATES=1) checked every
//   cycle against a transaction-level model, plus directed literal checks.
module tb_ram_arbiter;

  localparam int MAXV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][23:0] cpu_adr;
  logic [1:0]       cpu_wr, cpu_ben, cpu_wait;
  logic [1:0][31:0] cpu_wdata, cpu_rdata;
  logic [1:0]       vid_req, vid_ack;
  logic [1:0][21:0] vid_adr, mem_adr;
  logic [1:0][31:0] vid_rdata, mem_wdata, mem_rdata;
  logic [1:0]       mem_ce, mem_we;
  logic [1:0][3:0]  mem_be;

  ram_arbiter #(.ADDR_W(24), .WAIT_STATES(0), .MAX_VID_RUN(MAXV)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr[0]), .cpu_wr(cpu_wr[0]), .cpu_ben(cpu_ben[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_wait(cpu_wait[0]),
    .vid_req(vid_req[0]), .vid_adr(vid_adr[0]), .vid_ack(vid_ack[0]),
    .vid_rdata(vid_rdata[0]), .mem_adr(mem_adr[0]), .mem_ce(mem_ce[0]),
    .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]));

  ram_arbiter #(.ADDR_W(24), .WAIT_STATES(1), .MAX_VID_RUN(MAXV)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr[1]), .cpu_wr(cpu_wr[1]), .cpu_ben(cpu_ben[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_wait(cpu_wait[1]),
    .vid_req(vid_req[1]), .vid_adr(vid_adr[1]), .vid_ack(vid_ack[1]),
    .vid_rdata(vid_rdata[1]), .mem_adr(mem_adr[1]), .mem_ce(mem_ce[1]),
    .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic check(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, k, cyc, act, exp);
  endtask

  task automatic check_str(input string nm, input string act, input string exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
  endtask

  // Transaction-level model: an access is an owner, a frozen set of memory
  // lines and a number of remaining cycles.
  int          ws      [2] = '{0, 1};
  int          rem     [2];
  bit          owner_v [2];
  logic [21:0] madr    [2];
  logic [3:0]  mbe     [2];
  bit          mwe     [2];
  logic [31:0] mwd     [2];
  int          vrun    [2];
  bit          lastv   [2];
  bit          cpu_done[2];
  bit          vid_done[2];
  logic [3:0]  lane    [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit vw, fin;
      cpu_done[k] = 0;
      vid_done[k] = 0;
      if (rst) begin
        rem[k] = 0; vrun[k] = 0; lastv[k] = 0;
        check("rst_cpu_wait", k, 32'(cpu_wait[k]), 32'd1);
        check("rst_mem_ce",   k, 32'(mem_ce[k]),   32'd0);
        check("rst_mem_we",   k, 32'(mem_we[k]),   32'd0);
        check("rst_vid_ack",  k, 32'(vid_ack[k]),  32'd0);
      end else begin
        if (rem[k] == 0) begin
`ifdef RAM_ARBITER_RR_EN
          vw = vid_req[k] && !lastv[k];
`else
          vw = vid_req[k] && (vrun[k] < MAXV);
`endif
          lastv[k]   = vw;
          vrun[k]    = vw ? ((vrun[k] < MAXV) ? vrun[k] + 1 : vrun[k]) : 0;
          owner_v[k] = vw;
          rem[k]     = ws[k] + 1;
          madr[k]    = vw ? vid_adr[k] : cpu_adr[k][23:2];
          mwe[k]     = !vw && cpu_wr[k];
          mbe[k]     = (!vw && cpu_wr[k] && cpu_ben[k]) ? lane[cpu_adr[k][1:0]] : 4'hF;
          mwd[k]     = cpu_wdata[k];
        end
        fin = (rem[k] == 1);
        check("cpu_wait", k, 32'(cpu_wait[k]), 32'(!(fin && !owner_v[k])));
        check("vid_ack",  k, 32'(vid_ack[k]),  32'(fin && owner_v[k]));
        check("mem_ce",   k, 32'(mem_ce[k]),   32'd1);
        check("mem_we",   k, 32'(mem_we[k]),   32'(mwe[k]));
        check("mem_be",   k, 32'(mem_be[k]),   32'(mbe[k]));
        check("mem_adr",  k, 32'(mem_adr[k]),  32'(madr[k]));
        if (mwe[k]) check("mem_wdata", k, mem_wdata[k], mwd[k]);
        check("cpu_rdata", k, cpu_rdata[k], mem_rdata[k]);
        check("vid_rdata", k, vid_rdata[k], mem_rdata[k]);
        cpu_done[k] = fin && !owner_v[k];
        vid_done[k] = fin && owner_v[k];
        rem[k]--;
      end
    end
  end

  bit auto_cpu1 = 0;
  bit mixed     = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = $urandom;
      if (cpu_done[k] && (k == 0 || auto_cpu1)) begin
        if (mixed) begin
          cpu_adr[k]   = 24'($urandom);
          cpu_wr[k]    = 1'($urandom);
          cpu_ben[k]   = 1'($urandom);
          cpu_wdata[k] = $urandom;
        end else begin
          cpu_adr[k] = cpu_adr[k] + 24'd4;
        end
      end
      if (mixed) begin
        if (vid_done[k] || !vid_req[k]) begin
          vid_req[k] = ($urandom_range(3) != 0);
          vid_adr[k] = 22'($urandom);
        end else if ($urandom_range(15) == 0) begin
          vid_req[k] = 1'b0;
        end
      end
    end
  endtask

  string log1;

  initial begin
    rst = 1'b1;
    cpu_adr[0] = 24'h000100; cpu_wr[0] = 0; cpu_ben[0] = 0; cpu_wdata[0] = '0;
    vid_req[0] = 0; vid_adr[0] = '0; mem_rdata = '0;
    cpu_adr[1] = 24'h000007; cpu_wr[1] = 1; cpu_ben[1] = 1; cpu_wdata[1] = 32'hAAAAAAAA;
    vid_req[1] = 0; vid_adr[1] = '0;
    step(); step();
    step(); rst = 1'b0; cyc = 0;

    // cycle 0: first arbitration after reset
    @(negedge clk);
    check("t1_adr0", 0, 32'(mem_adr[0]), 32'h40);
    check("t1_wait0", 0, 32'(cpu_wait[0]), 32'd0);
    check("t2_be0", 1, 32'(mem_be[1]), 32'h8);
    check("t2_we0", 1, 32'(mem_we[1]), 32'd1);
    check("t2_wait0", 1, 32'(cpu_wait[1]), 32'd1);
    step();  // cycle 1
    @(negedge clk);
    check("t1_adr1", 0, 32'(mem_adr[0]), 32'h41);
    check("t1_wait1", 0, 32'(cpu_wait[0]), 32'd0);
    check("t2_be1", 1, 32'(mem_be[1]), 32'h8);
    check("t2_we1", 1, 32'(mem_we[1]), 32'd1);
    check("t2_wait1", 1, 32'(cpu_wait[1]), 32'd0);
    step();  // cycle 2: CPU read
    cpu_adr[1] = 24'h000200; cpu_wr[1] = 0; cpu_ben[1] = 0;
    step();  // cycle 3
    step();  // cycle 4: word store held, video requests continuously
    cpu_adr[1] = 24'h000300; cpu_wr[1] = 1; cpu_ben[1] = 0; cpu_wdata[1] = 32'h55555555;
    vid_req[1] = 1; vid_adr[1] = 22'h001000;
    log1 = "";
    for (int c = 4; c <= 15; c++) begin
      if (c != 4) step();
      @(negedge clk);
      if (vid_ack[1]) log1 = {log1, "V"};
      if (!cpu_wait[1]) log1 = {log1, "C"};
    end
`ifdef RAM_ARBITER_RR_EN
    check_str("t4_rr_grant_order", log1, "VCVCVC");
`else
    check_str("t3_vid_run_limit", log1, "VVVVCV");
`endif
    step();  // cycle 16: video granted
    step();  // cycle 17: request dropped, access completes anyway
    vid_req[1] = 0; vid_adr[1] = 22'h002AAA;
    @(negedge clk);
    check("t6_ack_after_drop", 1, 32'(vid_ack[1]), 32'd1);
    check("t6_adr_held", 1, 32'(mem_adr[1]), 32'h1000);
    step();  // cycle 18: CPU store granted
    @(negedge clk);
    check("t6_cpu_grant_we", 1, 32'(mem_we[1]), 32'd1);
    check("t6_cpu_grant_adr", 1, 32'(mem_adr[1]), 32'hC0);
    step();  // cycle 19: reset mid-access
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ce", 1, 32'(mem_ce[1]), 32'd0);
    check("t5_rst_we", 1, 32'(mem_we[1]), 32'd0);
    check("t5_rst_wait", 1, 32'(cpu_wait[1]), 32'd1);
    step();  // cycle 20: restart from IDLE
    rst = 1'b0;
    @(negedge clk);
    check("t5_restart_we", 1, 32'(mem_we[1]), 32'd1);
    check("t5_restart_wait", 1, 32'(cpu_wait[1]), 32'd1);
    step();  // cycle 21
    @(negedge clk);
    check("t5_restart_done", 1, 32'(cpu_wait[1]), 32'd0);

    auto_cpu1 = 1;
    mixed     = 1;
    repeat (400) step();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
